filter_line_ctrl: RTL and testbench

- Sequences the half-pel/quarter-pel line interpolation datapath (filter_half + filter_quarter) over a block of rows.
- On a start command, reads 8-pixel rows (64 b) from the reference line memory and drives each row onto the filters' cur_pix input.
- Registers the combinational 7 half-pel and 14 quarter-pel results, then hands them downstream on a valid/ready interface.
- Sits between the reference line buffer and the motion-compensation output stage.

---
 rtl/filter_line_ctrl.sv | 151 +++++++++++++++
 tb/tb_filter_line_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_line_ctrl.sv
// filter_line_ctrl
//   Sequences the half-pel / quarter-pel line interpolation datapath over a
//   block of rows. On start, each 8-pixel row is read from the reference line
//   memory and driven onto cur_pix. The combinational filter results are then
//   registered and presented downstream on a valid/ready handshake.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   start          command pulse, sampled only in IDLE
//   base_addr      line-memory address of row 0 (captured on start)
//   num_rows       rows to process (captured on start; 0 = no rows)
//   busy           high in every state except IDLE
//   done           one-cycle pulse after the last row is accepted
//   mem_rd_en      line-memory read strobe (one cycle per row)
//   mem_rd_addr    line-memory read address; holds between reads
//   mem_rd_data    read data, valid one cycle after mem_rd_en
//   cur_pix        registered row to the filters, pixel 0 in [7:0]
//   half_pix       combinational half-pel result from filter_half
//   quarter_pix    combinational quarter-pel result from filter_quarter
//   out_valid      result valid
//   out_ready      downstream accepts the result
//   out_half       registered half-pel row
//   out_quarter    registered quarter-pel row
//   out_row        0-based index of the presented row
module filter_line_ctrl #(
    parameter int ROW_W     = 64,
    parameter int HALF_W    = 56,
    parameter int QUARTER_W = 112,
    parameter int ADDR_W    = 6,
    parameter int CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     num_rows,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_rd_addr,
    input  logic [ROW_W-1:0]     mem_rd_data,
    output logic [ROW_W-1:0]     cur_pix,
    input  logic [HALF_W-1:0]    half_pix,
    input  logic [QUARTER_W-1:0] quarter_pix,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [HALF_W-1:0]    out_half,
    output logic [QUARTER_W-1:0] out_quarter,
    output logic [CNT_W-1:0]     out_row
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_FILT,
        S_OUT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_row;

    logic [CNT_W-1:0]    w_row_inc;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic                w_last_row;

    // The read strobe and address are registered, so the address for the
    // next row is formed one state early (on the OUT handshake).
    always_comb begin
        w_row_inc  = r_row + CNT_W'(1);
        w_addr_inc = r_base + ADDR_W'(w_row_inc);
        w_last_row = (r_row == (r_count - CNT_W'(1)));
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_count     <= '0;
            r_row       <= '0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            cur_pix     <= '0;
            out_valid   <= 1'b0;
            out_half    <= '0;
            out_quarter <= '0;
            out_row     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_count <= num_rows;
                        r_row   <= '0;
                        if (num_rows == '0) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= base_addr;
                            r_state     <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    mem_rd_en <= 1'b0;
                    r_state   <= S_LOAD;
                end
                S_LOAD: begin
                    cur_pix <= mem_rd_data;
                    r_state <= S_FILT;
                end
                S_FILT: begin
                    out_half    <= half_pix;
                    out_quarter <= quarter_pix;
                    out_row     <= r_row;
                    out_valid   <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (w_last_row) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row       <= w_row_inc;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= w_addr_inc;
                            r_state     <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_line_ctrl.sv
// Directed bench for filter_line_ctrl. A behavioural line memory returns
// 0x0706050403020100 + address one cycle after each read strobe, and a
// rounding-average filter model drives half_pix / quarter_pix from cur_pix.
module tb_filter_line_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic [5:0]   base_addr;
    logic [5:0]   num_rows;
    logic         busy;
    logic         done;
    logic         mem_rd_en;
    logic [5:0]   mem_rd_addr;
    logic [63:0]  mem_rd_data;
    logic [63:0]  cur_pix;
    logic [55:0]  half_pix;
    logic [111:0] quarter_pix;
    logic         out_valid;
    logic         out_ready;
    logic [55:0]  out_half;
    logic [111:0] out_quarter;
    logic [5:0]   out_row;

    int vectors;
    int miscompares;

    filter_line_ctrl #(
        .ROW_W     (64),
        .HALF_W    (56),
        .QUARTER_W (112),
        .ADDR_W    (6),
        .CNT_W     (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .num_rows    (num_rows),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .cur_pix     (cur_pix),
        .half_pix    (half_pix),
        .quarter_pix (quarter_pix),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_half    (out_half),
        .out_quarter (out_quarter),
        .out_row     (out_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rowval(input logic [5:0] a);
        logic [63:0] r;
        r = 64'h0706050403020100 + {58'd0, a};
        return r;
    endfunction

    function automatic logic [55:0] half_of(input logic [63:0] r);
        logic [55:0] h;
        logic [8:0]  s;
        h = '0;
        for (int i = 0; i < 7; i++) begin
            s = {1'b0, r[i*8 +: 8]} + {1'b0, r[(i+1)*8 +: 8]} + 9'd1;
            h[i*8 +: 8] = s[8:1];
        end
        return h;
    endfunction

    function automatic logic [111:0] quarter_of(input logic [63:0] r);
        logic [111:0] q;
        logic [55:0]  h;
        logic [8:0]   s;
        h = half_of(r);
        q = '0;
        for (int i = 0; i < 7; i++) begin
            s = {1'b0, r[i*8 +: 8]} + {1'b0, h[i*8 +: 8]} + 9'd1;
            q[(2*i)*8 +: 8] = s[8:1];
            s = {1'b0, h[i*8 +: 8]} + {1'b0, r[(i+1)*8 +: 8]} + 9'd1;
            q[(2*i+1)*8 +: 8] = s[8:1];
        end
        return q;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= rowval(mem_rd_addr);
    end

    always_comb begin
        half_pix    = half_of(cur_pix);
        quarter_pix = quarter_of(cur_pix);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [5:0] b, input logic [5:0] n);
        start     = 1'b1;
        base_addr = b;
        num_rows  = n;
        tick;
        start = 1'b0;
    endtask

    // Entered in the READ cycle of a row; leaves after the handshake edge.
    task automatic run_row(input logic [5:0] addr, input logic [5:0] row,
                           input int stall, input bit pulse_start);
        out_ready = (stall == 0);
        if (pulse_start) begin
            start     = 1'b1;
            base_addr = 6'h10;
            num_rows  = 6'd1;
        end
        chk("rd_en_read", mem_rd_en, 1'b1);
        chk("rd_addr", mem_rd_addr, addr);
        chk("busy_read", busy, 1'b1);
        tick;
        start = 1'b0;
        chk("rd_en_load", mem_rd_en, 1'b0);
        chk("rd_addr_hold", mem_rd_addr, addr);
        tick;
        chk("cur_pix", cur_pix, rowval(addr));
        chk("valid_filt", out_valid, 1'b0);
        tick;
        chk("valid_out", out_valid, 1'b1);
        chk("out_row", out_row, row);
        chk("out_half", out_half, half_of(rowval(addr)));
        chk("out_quarter", out_quarter, quarter_of(rowval(addr)));
        for (int i = 1; i < stall; i++) begin
            tick;
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_half", out_half, half_of(rowval(addr)));
            chk("stall_quarter", out_quarter, quarter_of(rowval(addr)));
            chk("stall_row", out_row, row);
            chk("stall_no_read", mem_rd_en, 1'b0);
        end
        out_ready = 1'b1;
        tick;
        chk("valid_drop", out_valid, 1'b0);
    endtask

    task automatic finish_block(input logic [5:0] last_addr);
        chk("done_pulse", done, 1'b1);
        chk("busy_done", busy, 1'b1);
        chk("no_read_done", mem_rd_en, 1'b0);
        tick;
        chk("done_clear", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("cur_pix_hold", cur_pix, rowval(last_addr));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        num_rows    = '0;
        out_ready   = 1'b1;
        tick;
        tick;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_addr", mem_rd_addr, 6'd0);
        chk("rst_cur_pix", cur_pix, 64'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_half", out_half, 56'd0);
        chk("rst_quarter", out_quarter, 112'd0);
        chk("rst_row", out_row, 6'd0);
        rst = 1'b0;
        tick;

        // Three rows from 0x05, reads on cycles 1, 5, 9 after start.
        do_start(6'h05, 6'd3);
        run_row(6'h05, 6'd0, 0, 1'b0);
        run_row(6'h06, 6'd1, 0, 1'b0);
        run_row(6'h07, 6'd2, 0, 1'b0);
        finish_block(6'h07);

        // Address wrap; a start during row 1 must not disturb the block.
        do_start(6'h3E, 6'd4);
        run_row(6'h3E, 6'd0, 0, 1'b0);
        run_row(6'h3F, 6'd1, 0, 1'b1);
        run_row(6'h00, 6'd2, 0, 1'b0);
        run_row(6'h01, 6'd3, 0, 1'b0);
        finish_block(6'h01);

        // Downstream stall of 10 cycles on row 1.
        do_start(6'h20, 6'd3);
        run_row(6'h20, 6'd0, 0, 1'b0);
        run_row(6'h21, 6'd1, 10, 1'b0);
        run_row(6'h22, 6'd2, 0, 1'b0);
        finish_block(6'h22);

        // Empty block, then a start in the cycle right after done.
        do_start(6'h30, 6'd0);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b1);
        chk("zero_no_read", mem_rd_en, 1'b0);
        tick;
        chk("zero_done_clear", done, 1'b0);
        chk("zero_busy_clear", busy, 1'b0);
        chk("zero_no_read2", mem_rd_en, 1'b0);
        do_start(6'h12, 6'd1);
        run_row(6'h12, 6'd0, 0, 1'b0);
        finish_block(6'h12);

        // Reset while row 1 of 3 is presented.
        do_start(6'h00, 6'd3);
        run_row(6'h00, 6'd0, 0, 1'b0);
        out_ready = 1'b0;
        tick;
        tick;
        tick;
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_row", out_row, 6'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_cur_pix", cur_pix, 64'd0);
        chk("mid_rst_half", out_half, 56'd0);
        chk("mid_rst_quarter", out_quarter, 112'd0);
        chk("mid_rst_row", out_row, 6'd0);
        chk("mid_rst_addr", mem_rd_addr, 6'd0);
        out_ready = 1'b1;
        tick;
        chk("rst_no_done", done, 1'b0);
        tick;
        chk("rst_no_done2", done, 1'b0);
        rst = 1'b0;
        tick;
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        do_start(6'h08, 6'd2);
        run_row(6'h08, 6'd0, 0, 1'b0);
        run_row(6'h09, 6'd1, 0, 1'b0);
        finish_block(6'h09);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
